// File: rtl/fconv_sched.sv
// Round-robin scheduler sharing one pipelined float<->int conversion unit among N_REQ issue slots.
// A tag pipe that tracks the unit latency routes each result back to the slot that issued it.
module fconv_sched #(
  parameter int N_REQ = 2,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_op,
  input  logic [32*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cv_valid,
  output logic                      cv_op,
  output logic [31:0]               cv_x,
  input  logic [31:0]               cv_y,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [31:0]               rsp_data,
  output logic [$clog2(LAT+1)-1:0]  inflight,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int INF_W = $clog2(LAT+1);

  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic [LAT-1:0]   tvld_q;
  logic [ID_W-1:0]  tid_q [LAT];
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stall_evt;

  // Arbitration: scan from the slot after the last grant; nothing is granted in reset or flush.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    if (rstn && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = ID_W'((int'(last_q) + 1 + k) % N_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
    cv_valid  = gnt_any;
    cv_op     = gnt_any ? req_op[gnt_id] : 1'b0;
    cv_x      = gnt_any ? req_data[32*gnt_id +: 32] : 32'h0;
    last_d    = gnt_any ? gnt_id : last_q;
  end

  // Reset pointer to the last slot so slot 0 wins the first search.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= ID_W'(N_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

  // Tag pipe stage boundary: valid bits are control, flush drops everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tvld_q <= '0;
    end else if (flush) begin
      tvld_q <= '0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        tvld_q[i] <= tvld_q[i-1];
      end
      tvld_q[0] <= cv_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) begin
      tid_q[i] <= tid_q[i-1];
    end
    tid_q[0] <= gnt_id;
  end

  always_comb begin
    rsp_valid = (tvld_q[LAT-1] && !flush) ? (N_REQ'(1) << tid_q[LAT-1]) : '0;
    rsp_data  = (|rsp_valid) ? cv_y : 32'h0;
    inflight  = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + INF_W'(tvld_q[i]);
    end
  end

  // Stall counter saturates rather than wrapping so long starvation stays visible.
  always_comb begin
    stall_evt = |(req_valid & ~req_ready);
    stall_d   = stall_q;
    if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fconv_sched.sv
// Randomized scoreboard bench for fconv_sched with a latency-LAT inverting conversion stub.
module tb_fconv_sched;

  localparam int N_REQ = 2;
  localparam int LAT   = 3;
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     flush = 1'b0;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [N_REQ-1:0]         req_op = '0;
  logic [32*N_REQ-1:0]      req_data = '0;
  logic [N_REQ-1:0]         req_ready;
  logic                     cv_valid;
  logic                     cv_op;
  logic [31:0]              cv_x;
  logic [31:0]              cv_y;
  logic [N_REQ-1:0]         rsp_valid;
  logic [31:0]              rsp_data;
  logic [$clog2(LAT+1)-1:0] inflight;
  logic [CNT_W-1:0]         stall_cnt;

  fconv_sched #(.N_REQ(N_REQ), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .cv_valid(cv_valid), .cv_op(cv_op), .cv_x(cv_x), .cv_y(cv_y),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Conversion stub: result is the inverted operand, LAT cycles later.
  logic [31:0] ypipe [LAT];
  always @(posedge clk) begin
    ypipe[0] <= cv_x ^ 32'hFFFF_FFFF;
    for (int i = 1; i < LAT; i++) ypipe[i] <= ypipe[i-1];
  end
  assign cv_y = ypipe[LAT-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int peak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {int slot; logic [31:0] data; int due;} exp_t;
  exp_t q[$];
  int m_last = N_REQ - 1;
  int m_stall = 0;

  // Reference model and monitor, evaluated mid-cycle when all inputs are stable.
  always @(negedge clk) begin
    int g, n;
    logic [N_REQ-1:0] e_ready, e_rv;
    logic [31:0] e_rd;
    if (!rstn) begin
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_cv", {31'(0), cv_valid, cv_op, cv_x}, 64'(0));
      chk("rst_rsp", {30'(0), rsp_valid, rsp_data}, 64'(0));
      chk("rst_stall", 64'(stall_cnt), 64'(0));
      chk("rst_inflight", 64'(inflight), 64'(0));
      q.delete();
      m_last = N_REQ - 1;
      m_stall = 0;
    end else begin
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      n = 0;
      foreach (q[i]) if (q[i].due < cyc + LAT) n++;
      chk("inflight", 64'(inflight), 64'(n));
      if (int'(inflight) > peak) peak = int'(inflight);
      e_rv = '0;
      e_rd = 32'h0;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (!flush) begin
          e_rv = N_REQ'(1) << q[0].slot;
          e_rd = q[0].data;
        end
        void'(q.pop_front());
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_data", 64'(rsp_data), 64'(e_rd));
      g = -1;
      if (!flush) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (g < 0 && req_valid[(m_last + 1 + k) % N_REQ]) g = (m_last + 1 + k) % N_REQ;
        end
      end
      e_ready = (g >= 0) ? (N_REQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("cv_valid", 64'(cv_valid), 64'(g >= 0));
      chk("cv_op", 64'(cv_op), (g >= 0) ? 64'(req_op[g]) : 64'(0));
      chk("cv_x", 64'(cv_x), (g >= 0) ? 64'(req_data[32*g +: 32]) : 64'(0));
      if (flush) q.delete();
      else if (g >= 0) q.push_back('{g, ~req_data[32*g +: 32], cyc + LAT});
      if (g >= 0) m_last = g;
      if (|(req_valid & ~e_ready) && m_stall < SMAX) m_stall++;
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] op,
                      input logic [31:0] d0, input logic [31:0] d1, input logic fl);
    req_valid = v;
    req_op = op;
    req_data = {d1, d0};
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    req_valid = 2'b11;
    req_data = {32'h1234_5678, 32'h9ABC_DEF0};
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    // T1 single op from slot 0
    step(2'b01, 2'b00, 32'h4049_0FDB, 32'h0, 1'b0);
    idle(LAT + 1);
    // T2 contention: alternating grants
    for (int i = 0; i < 6; i++) step(2'b11, 2'($urandom), $urandom, $urandom, 1'b0);
    chk("t2_stall", 64'(stall_cnt), 64'(6));
    idle(LAT + 1);
    // T3 fairness
    step(2'b10, 2'b11, $urandom, $urandom, 1'b0);
    step(2'b11, 2'b01, $urandom, $urandom, 1'b0);
    step(2'b11, 2'b10, $urandom, $urandom, 1'b0);
    idle(LAT + 1);
    // T4 flush kills in-flight ops
    step(2'b01, 2'b00, $urandom, 32'h0, 1'b0);
    step(2'b01, 2'b01, $urandom, 32'h0, 1'b0);
    step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("t4_inflight", 64'(inflight), 64'(0));
    step(2'b11, 2'b00, $urandom, $urandom, 1'b1);
    idle(LAT + 1);
    // T5 back-to-back from slot 0
    peak = 0;
    for (int i = 0; i < 8; i++) step(2'b01, 2'($urandom), $urandom, 32'h0, 1'b0);
    idle(LAT + 1);
    chk("t5_peak", 64'(peak), 64'(LAT));
    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++)
      step(2'($urandom), 2'($urandom), $urandom, $urandom, ($urandom_range(0, 7) == 0));
    // T6 async reset mid-stream
    step(2'b11, 2'b01, $urandom, $urandom, 1'b0);
    step(2'b11, 2'b10, $urandom, $urandom, 1'b0);
    req_valid = 2'b11;
    #2 rstn = 1'b0;
    #1;
    chk("t6_ready", 64'(req_ready), 64'(0));
    chk("t6_cv_valid", 64'(cv_valid), 64'(0));
    chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t6_stall", 64'(stall_cnt), 64'(0));
    chk("t6_inflight", 64'(inflight), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    step(2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(2'b11, 2'b00, $urandom, $urandom, 1'b0);
    idle(LAT + 2);
    chk("drain_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
